// File: rtl/pc_sequencer_if.sv
// Fetch-address sequencer bus: hazard/redirect requests in,
// fetch PC, flush controls and status out.
interface pc_sequencer_if;
    logic        stall;
    logic        id_jump;
    logic        id_valid;
    logic [25:0] id_instr_index;
    logic [31:0] id_pc_plus4;
    logic        ex_branch_taken;
    logic [31:0] ex_branch_target;
    logic        ex_jr;
    logic [31:0] ex_jr_target;
    logic        halt;
    logic [31:0] pc;
    logic        flush_if;
    logic        flush_id;
    logic        halted;
    logic        misalign;
    logic [15:0] redirect_cnt;

    modport master (
        output stall, id_jump, id_valid, id_instr_index,
        output id_pc_plus4, ex_branch_taken, ex_branch_target,
        output ex_jr, ex_jr_target, halt,
        input  pc, flush_if, flush_id, halted, misalign,
        input  redirect_cnt
    );

    modport slave (
        input  stall, id_jump, id_valid, id_instr_index,
        input  id_pc_plus4, ex_branch_taken, ex_branch_target,
        input  ex_jr, ex_jr_target, halt,
        output pc, flush_if, flush_id, halted, misalign,
        output redirect_cnt
    );
endinterface

// File: rtl/pc_sequencer.sv
// Fetch PC sequencer: EX redirects, ID jumps, stall hold,
// halt and misaligned-target trap with a saturating redirect counter.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic          clk,
    input  logic          rst,
    pc_sequencer_if.slave bus
);
    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic        r_misalign;
    logic [15:0] r_cnt;

    logic        w_run;
    logic        w_ex_redir;
    logic        w_ex_bad;
    logic        w_id_jump;
    logic        w_halt;
    logic [31:0] w_ex_target;
    logic [31:0] w_jump_target;
    logic [15:0] w_cnt_inc;

    assign w_run      = !rst && (r_state == RUN);
    assign w_ex_redir = bus.ex_branch_taken || bus.ex_jr;
    assign w_ex_target = bus.ex_jr ? bus.ex_jr_target
                                   : bus.ex_branch_target;
    assign w_ex_bad   = (w_ex_target[1:0] != 2'b00);
    assign w_id_jump  = bus.id_valid && bus.id_jump && !bus.stall;
    assign w_halt     = bus.id_valid && bus.halt && !bus.stall;

    // Region bits come from the delay-slot PC, not the jump's own PC
    assign w_jump_target = (bus.id_pc_plus4 & 32'hF000_0000)
                         | {4'b0000, bus.id_instr_index, 2'b00};

    assign w_cnt_inc = (r_cnt == 16'hFFFF) ? r_cnt
                                           : r_cnt + 16'd1;

    assign bus.flush_if     = w_run && (w_ex_redir || w_id_jump);
    assign bus.flush_id     = w_run && w_ex_redir;
    assign bus.pc           = r_pc;
    assign bus.halted       = (r_state == HALTED);
    assign bus.misalign     = r_misalign;
    assign bus.redirect_cnt = r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= RUN;
            r_pc       <= RESET_PC;
            r_misalign <= 1'b0;
            r_cnt      <= 16'd0;
        end else begin
            case (r_state)
                RUN: begin
                    if (w_ex_redir) begin
                        if (w_ex_bad) begin
                            r_misalign <= 1'b1;
                            r_state    <= HALTED;
                        end else begin
                            r_pc  <= w_ex_target;
                            r_cnt <= w_cnt_inc;
                        end
                    end else if (w_halt) begin
                        r_state <= HALTED;
                    end else if (w_id_jump) begin
                        r_pc  <= w_jump_target;
                        r_cnt <= w_cnt_inc;
                    end else if (!bus.stall) begin
                        r_pc <= r_pc + 32'd4;
                    end
                end
                HALTED: begin
                    r_state <= HALTED;
                end
                default: begin
                    r_state <= RUN;
                end
            endcase
        end
    end
endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_3000: PC value loaded on reset.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port stall, input, 1 bit: hazard hold request from ID.
REQ-005 The block SHALL have port id_jump, input, 1 bit: J/JAL decoded in ID, qualified by id_valid.
REQ-006 The block SHALL have port id_valid, input, 1 bit: ID stage holds a real instruction.
REQ-007 The block SHALL have port id_instr_index, input, 26 bits: instruction bits [25:0].
REQ-008 The block SHALL have port id_pc_plus4, input, 32 bits: PC+4 of the ID instruction.
REQ-009 The block SHALL have port ex_branch_taken, input, 1 bit: resolved taken branch in EX.
REQ-010 The block SHALL have port ex_branch_target, input, 32 bits: branch target address.
REQ-011 The block SHALL have port ex_jr, input, 1 bit: JR/JALR in EX.
REQ-012 The block SHALL have port ex_jr_target, input, 32 bits: register target address.
REQ-013 The block SHALL have port halt, input, 1 bit: halt/syscall-exit request from ID.
REQ-014 The block SHALL have port pc, output, 32 bits: registered fetch address.
REQ-015 The block SHALL have port flush_if, output, 1 bit: kill the IF/ID register contents.
REQ-016 The block SHALL have port flush_id, output, 1 bit: kill the ID/EX register contents.
REQ-017 The block SHALL have port halted, output, 1 bit: high in HALTED state.
REQ-018 The block SHALL have port misalign, output, 1 bit: sticky flag for a misaligned redirect target.
REQ-019 The block SHALL have port redirect_cnt, output, 16 bits: count of accepted redirects.

Function
REQ-020 The state machine SHALL have two states: RUN and HALTED.
REQ-021 The jump target SHALL be {id_pc_plus4[31:28], id_instr_index, 2'b00}.
REQ-022 EX redirect SHALL be defined as ex_branch_taken OR ex_jr; when both are asserted, ex_jr_target SHALL be used.
REQ-023 ID jump SHALL be defined as id_valid AND id_jump AND NOT stall.
REQ-024 Next PC priority in RUN SHALL be: EX redirect > ID jump > stall (hold) > pc+4, with 32-bit wrap-around (32'hFFFF_FFFC+4 gives 0).
REQ-025 EX redirect SHALL override stall.
REQ-026 pc SHALL update one edge after the redirect condition, giving 1-cycle latency.
REQ-027 flush_if SHALL be combinational and SHALL be 1 in the same cycle as an EX redirect or ID jump in RUN.
REQ-028 flush_id SHALL be combinational and SHALL be 1 only in the same cycle as an EX redirect in RUN.
REQ-029 If the selected EX target has bits [1:0] != 0, pc SHALL hold, misalign SHALL set, the state SHALL go to HALTED, redirect_cnt SHALL NOT increment, and flush_if/flush_id SHALL still be asserted that cycle.
REQ-030 halt (with id_valid, no EX redirect, no stall) SHALL cause pc to hold and the state to go to HALTED on the next edge.
REQ-031 If an EX redirect coincides with halt, the redirect SHALL win and halt SHALL be ignored.
REQ-032 In HALTED, pc SHALL hold, all inputs SHALL be ignored, flush_if and flush_id SHALL be 0, and only rst SHALL exit the state.
REQ-033 redirect_cnt SHALL increment on each accepted EX redirect or ID jump and SHALL saturate at 16'hFFFF.

Reset
REQ-034 When rst=1 at a rising edge: pc SHALL become RESET_PC, the state SHALL become RUN, misalign SHALL become 0, and redirect_cnt SHALL become 0.
REQ-035 While rst=1, flush_if and flush_id SHALL be 0.
REQ-036 rst SHALL override every concurrent event, including a reset asserted mid-halt or in the same cycle as a redirect.

Verification
REQ-037 After reset, with no events for 3 cycles -> pc SHALL step 32'h3000, 3004, 3008, 300C.
REQ-038 id_valid=1, id_jump=1, id_instr_index=26'h0000_100, id_pc_plus4=32'h1000_3008 -> flush_if=1 and flush_id=0 that cycle; next pc SHALL be 32'h1000_0400; redirect_cnt SHALL be 1.
REQ-039 stall=1 with id_jump=1 held for 2 cycles -> pc SHALL be held and flush_if=0; after stall drops -> the jump SHALL be taken.
REQ-040 ex_branch_taken=1, target 32'h3100, with stall=1 and id_jump=1 in the same cycle -> flush_if=1 and flush_id=1; next pc SHALL be 32'h3100.
REQ-041 ex_jr=1 with ex_jr_target=32'h3002 -> misalign=1, halted=1, and pc SHALL be unchanged; then rst -> pc=RESET_PC and misalign=0.
REQ-042 halt in RUN -> halted=1; subsequent jumps and branches SHALL be ignored; redirect_cnt forced to 16'hFFFF plus one more jump (before halt) -> SHALL stay 16'hFFFF.
